// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;  // default register width
    localparam int ADDR_W_DEF = 4;   // default address width (16 registers)
    localparam int NUM_RD_MAX = 4;   // largest supported read-port count

    // Reset contents of register idx: its own index. The caller narrows or
    // zero-extends to DATA_W. Index 0 naturally yields 0.
    function automatic logic [31:0] reg_init_val(input int idx);
        return idx[31:0];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets a bit, write-back clears it.
// Latency: busy set/clear and o_busy_cnt registered (1 cycle); lookup is combinational.
// Backpressure: none, every set/clear strobe is accepted in its cycle.
//
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_clr_a_en/_addr, i_clr_b_en/_addr   write-back clears (already qualified)
//   i_set_en, i_set_addr            reserve request (already qualified)
//   i_rd_addr / o_rd_busy           per-read-port busy lookup
//   o_busy_cnt                      registered popcount of the busy vector
module regfile_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clr_a_en,
    input  logic [ADDR_W-1:0]        i_clr_a_addr,
    input  logic                     i_clr_b_en,
    input  logic [ADDR_W-1:0]        i_clr_b_addr,
    input  logic                     i_set_en,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic [ADDR_W:0]          o_busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        if (i_clr_a_en) busy_d[i_clr_a_addr] = 1'b0;
        if (i_clr_b_en) busy_d[i_clr_b_addr] = 1'b0;
        // The reserve comes from a younger instruction than the write-back,
        // so it overrides a clear of the same register.
        if (i_set_en)   busy_d[i_set_addr]   = 1'b1;

        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A write-back landing this cycle hides the stale busy bit immediately;
    // a same-cycle reserve only shows up after the edge.
    always_comb begin
        o_rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = i_rd_addr[k*ADDR_W +: ADDR_W];
            o_rd_busy[k] = busy_q[a]
                         && !(i_clr_a_en && (i_clr_a_addr == a))
                         && !(i_clr_b_en && (i_clr_b_addr == a));
        end
    end

    assign o_busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD read ports, two write ports, write-to-read bypass, busy scoreboard.
// Latency: reads combinational (0 cycles), writes commit on the rising edge, busy count registered.
// Backpressure: none, all writes/reserves are single-cycle strobes that are always accepted.
//
// Ports:
//   i_clk, i_reset                          clock, synchronous active-high reset
//   i_rd_addr / o_rd_data / o_rd_busy       packed per-port read address, data, busy
//   i_wr_en_a/_addr_a/_data_a               write port A (ALU write-back)
//   i_wr_en_b/_addr_b/_data_b               write port B (load write-back, wins on conflict)
//   i_rsv_en / i_rsv_addr                   destination reserve from decode
//   o_busy_cnt                              registered number of busy registers
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr_en_a,
    input  logic [ADDR_W-1:0]        i_wr_addr_a,
    input  logic [DATA_W-1:0]        i_wr_data_a,
    input  logic                     i_wr_en_b,
    input  logic [ADDR_W-1:0]        i_wr_addr_b,
    input  logic [DATA_W-1:0]        i_wr_data_b,
    input  logic                     i_rsv_en,
    input  logic [ADDR_W-1:0]        i_rsv_addr,
    output logic [ADDR_W:0]          o_busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_RD > NUM_RD_MAX) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD out of range");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // With ZERO_REG, anything aimed at register 0 is dropped here, so storage,
    // bypass and scoreboard never see it.
    logic wr_a_ok, wr_b_ok, rsv_ok;
    assign wr_a_ok = i_wr_en_a && !(ZERO_REG && (i_wr_addr_a == '0));
    assign wr_b_ok = i_wr_en_b && !(ZERO_REG && (i_wr_addr_b == '0));
    assign rsv_ok  = i_rsv_en  && !(ZERO_REG && (i_rsv_addr  == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_a_ok) mem_d[i_wr_addr_a] = i_wr_data_a;
        // B is applied last so it owns the data on an address conflict.
        if (wr_b_ok) mem_d[i_wr_addr_b] = i_wr_data_b;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(reg_init_val(i));
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read path: same-cycle write data bypasses storage, B ahead of A.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = i_rd_addr[k*ADDR_W +: ADDR_W];
            if (ZERO_REG && (a == '0))
                o_rd_data[k*DATA_W +: DATA_W] = '0;
            else if (wr_b_ok && (i_wr_addr_b == a))
                o_rd_data[k*DATA_W +: DATA_W] = i_wr_data_b;
            else if (wr_a_ok && (i_wr_addr_a == a))
                o_rd_data[k*DATA_W +: DATA_W] = i_wr_data_a;
            else
                o_rd_data[k*DATA_W +: DATA_W] = mem_q[a];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr_a_en   (wr_a_ok),
        .i_clr_a_addr (i_wr_addr_a),
        .i_clr_b_en   (wr_b_ok),
        .i_clr_b_addr (i_wr_addr_b),
        .i_set_en     (rsv_ok),
        .i_set_addr   (i_rsv_addr),
        .i_rd_addr    (i_rd_addr),
        .o_rd_busy    (o_rd_busy),
        .o_busy_cnt   (o_busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 16x16/2-port build plus a 32x32/3-port ZERO_REG build.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- default instance: DATA_W=16, ADDR_W=4, NUM_RD=2 ----------------
    logic        rst0;
    logic [7:0]  ra0;
    logic [31:0] rd0;
    logic [1:0]  rb0;
    logic        wea0, web0, rsv0;
    logic [3:0]  waa0, wab0, rsa0;
    logic [15:0] wda0, wdb0;
    logic [4:0]  cnt0;

    regfile_mp u_dut0 (
        .i_clk       (clk),
        .i_reset     (rst0),
        .i_rd_addr   (ra0),
        .o_rd_data   (rd0),
        .o_rd_busy   (rb0),
        .i_wr_en_a   (wea0),
        .i_wr_addr_a (waa0),
        .i_wr_data_a (wda0),
        .i_wr_en_b   (web0),
        .i_wr_addr_b (wab0),
        .i_wr_data_b (wdb0),
        .i_rsv_en    (rsv0),
        .i_rsv_addr  (rsa0),
        .o_busy_cnt  (cnt0)
    );

    // ---------------- sweep instance: DATA_W=32, ADDR_W=5, NUM_RD=3, ZERO_REG=1 ----------------
    logic        rst1;
    logic [14:0] ra1;
    logic [95:0] rd1;
    logic [2:0]  rb1;
    logic        wea1, web1, rsv1;
    logic [4:0]  waa1, wab1, rsa1;
    logic [31:0] wda1, wdb1;
    logic [5:0]  cnt1;

    regfile_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (3),
        .ZERO_REG (1'b1)
    ) u_dut1 (
        .i_clk       (clk),
        .i_reset     (rst1),
        .i_rd_addr   (ra1),
        .o_rd_data   (rd1),
        .o_rd_busy   (rb1),
        .i_wr_en_a   (wea1),
        .i_wr_addr_a (waa1),
        .i_wr_data_a (wda1),
        .i_wr_en_b   (web1),
        .i_wr_addr_b (wab1),
        .i_wr_data_b (wdb1),
        .i_rsv_en    (rsv1),
        .i_rsv_addr  (rsa1),
        .o_busy_cnt  (cnt1)
    );

    initial begin
        rst0 = 1'b1; ra0 = '0; wea0 = 1'b0; web0 = 1'b0; rsv0 = 1'b0;
        waa0 = '0; wab0 = '0; rsa0 = '0; wda0 = '0; wdb0 = '0;
        rst1 = 1'b1; ra1 = '0; wea1 = 1'b0; web1 = 1'b0; rsv1 = 1'b0;
        waa1 = '0; wab1 = '0; rsa1 = '0; wda1 = '0; wdb1 = '0;

        // ---- reset state: port0 reads r5, port1 reads r15 ----
        ra0 = {4'd15, 4'd5};
        tick();
        rst0 = 1'b0;
        #1;
        check("rst_rd_data", 64'(rd0), 64'h000F_0005);
        check("rst_rd_busy", 64'(rb0), 64'h0);
        check("rst_busy_cnt", 64'(cnt0), 64'h0);

        // ---- port A bypass to r3 ----
        ra0 = {4'd0, 4'd3};
        wea0 = 1'b1; waa0 = 4'd3; wda0 = 16'h1234;
        #1;
        check("bypass_a_r3", 64'(rd0[15:0]), 64'h1234);
        tick();
        wea0 = 1'b0;
        #1;
        check("store_r3", 64'(rd0[15:0]), 64'h1234);

        // ---- A and B both write r7: B wins, visible on port 1 ----
        ra0 = {4'd7, 4'd3};
        wea0 = 1'b1; waa0 = 4'd7; wda0 = 16'hAAAA;
        web0 = 1'b1; wab0 = 4'd7; wdb0 = 16'h5555;
        #1;
        check("bypass_conflict_r7", 64'(rd0[31:16]), 64'h5555);
        tick();
        wea0 = 1'b0; web0 = 1'b0;
        #1;
        check("store_conflict_r7", 64'(rd0[31:16]), 64'h5555);

        // ---- reserve r4: not visible same cycle, visible next ----
        ra0 = {4'd7, 4'd4};
        rsv0 = 1'b1; rsa0 = 4'd4;
        #1;
        check("rsv_same_cycle_busy", 64'(rb0), 64'h0);
        tick();
        rsv0 = 1'b0;
        #1;
        check("rsv_r4_busy", 64'(rb0), 64'h1);
        check("rsv_r4_cnt", 64'(cnt0), 64'h1);

        // ---- port B write-back to r4 clears busy combinationally ----
        web0 = 1'b1; wab0 = 4'd4; wdb0 = 16'h4444;
        #1;
        check("wb_r4_busy_now", 64'(rb0), 64'h0);
        check("wb_r4_cnt_now", 64'(cnt0), 64'h1);
        tick();
        web0 = 1'b0;
        #1;
        check("wb_r4_cnt_after", 64'(cnt0), 64'h0);
        check("wb_r4_data", 64'(rd0[15:0]), 64'h4444);

        // ---- reserve and write r4 together: data lands, reserve wins ----
        rsv0 = 1'b1; rsa0 = 4'd4;
        wea0 = 1'b1; waa0 = 4'd4; wda0 = 16'h4545;
        tick();
        rsv0 = 1'b0; wea0 = 1'b0;
        #1;
        check("rsv_wr_r4_data", 64'(rd0[15:0]), 64'h4545);
        check("rsv_wr_r4_busy", 64'(rb0), 64'h1);
        check("rsv_wr_r4_cnt", 64'(cnt0), 64'h1);

        // ---- reserve r1,r2,r3 and write r9, then reset mid-operation ----
        rsv0 = 1'b1; rsa0 = 4'd1;
        wea0 = 1'b1; waa0 = 4'd9; wda0 = 16'hBEEF;
        tick();
        wea0 = 1'b0; rsa0 = 4'd2;
        tick();
        rsa0 = 4'd3;
        tick();
        rsv0 = 1'b0;
        ra0 = {4'd4, 4'd9};
        #1;
        check("pre_rst_cnt", 64'(cnt0), 64'h4);
        check("pre_rst_r9", 64'(rd0[15:0]), 64'hBEEF);
        rst0 = 1'b1;
        wea0 = 1'b1; waa0 = 4'd9; wda0 = 16'h1111;
        rsv0 = 1'b1; rsa0 = 4'd5;
        tick();
        rst0 = 1'b0; wea0 = 1'b0; rsv0 = 1'b0;
        #1;
        check("mid_rst_rd_data", 64'(rd0), 64'h0004_0009);
        check("mid_rst_busy", 64'(rb0), 64'h0);
        check("mid_rst_cnt", 64'(cnt0), 64'h0);

        // ---- fill the whole scoreboard: count reaches DEPTH without wrapping ----
        rsv0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rsa0 = 4'(i);
            tick();
        end
        rsv0 = 1'b0;
        #1;
        check("full_cnt", 64'(cnt0), 64'd16);
        ra0 = {4'd10, 4'd2};
        wea0 = 1'b1; waa0 = 4'd2;  wda0 = 16'h0202;
        web0 = 1'b1; wab0 = 4'd10; wdb0 = 16'h1010;
        #1;
        check("dual_clear_busy_now", 64'(rb0), 64'h0);
        tick();
        wea0 = 1'b0; web0 = 1'b0;
        #1;
        check("dual_clear_cnt", 64'(cnt0), 64'd14);
        check("dual_clear_data", 64'(rd0), 64'h1010_0202);

        // ---- sweep instance: reset values of r30/r31/r0 ----
        ra1 = {5'd0, 5'd31, 5'd30};
        tick();
        rst1 = 1'b0;
        #1;
        check("sw_rst_r30", 64'(rd1[31:0]),  64'h0000_001E);
        check("sw_rst_r31", 64'(rd1[63:32]), 64'h0000_001F);
        check("sw_rst_r0",  64'(rd1[95:64]), 64'h0);
        check("sw_rst_cnt", 64'(cnt1), 64'h0);

        // ---- ZERO_REG: write and reserve r0 are ignored; B bypass on r31 ----
        wea1 = 1'b1; waa1 = 5'd0;  wda1 = 32'h0000_FFFF;
        web1 = 1'b1; wab1 = 5'd31; wdb1 = 32'hDEAD_BEEF;
        rsv1 = 1'b1; rsa1 = 5'd0;
        #1;
        check("zr_r0_bypass", 64'(rd1[95:64]), 64'h0);
        check("sw_r31_bypass", 64'(rd1[63:32]), 64'hDEAD_BEEF);
        tick();
        wea1 = 1'b0; web1 = 1'b0; rsv1 = 1'b0;
        #1;
        check("zr_r0_data", 64'(rd1[95:64]), 64'h0);
        check("zr_busy", 64'(rb1), 64'h0);
        check("zr_cnt", 64'(cnt1), 64'h0);
        check("sw_r31_store", 64'(rd1[63:32]), 64'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
